// File: rtl/aes_package.sv
// Shared types for the AES accelerator: core sequencing state and the
// state encoding of the TCDM word port.
package aes_package;

  // Core round sequencing state.
  typedef enum logic [1:0] {
    AES_IDLE,
    AES_KEY_EXP,
    AES_ROUND,
    AES_FINAL
  } aes_state_t;

  // Single-word TCDM port state.
  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_OUT,
    WR_DATA,
    WR_REQ,
    DONE
  } aes_port_state_t;

endpackage

// File: rtl/aes_tcdm_word_port.sv
// Single-word TCDM port: moves one word from memory to a stream consumer
// (source) or from a stream producer to memory (sink), one transfer at a time.
module aes_tcdm_word_port
  import aes_package::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  // read-word request and output stream
  input  logic            src_req_start_i,
  input  logic [AW-1:0]   src_base_addr_i,
  output logic            src_ready_start_o,
  output logic            src_done_o,
  output logic [DW-1:0]   src_data_o,
  output logic            src_valid_o,
  input  logic            src_ready_i,
  // write-word request and input stream
  input  logic            snk_req_start_i,
  input  logic [AW-1:0]   snk_base_addr_i,
  output logic            snk_ready_start_o,
  output logic            snk_done_o,
  input  logic [DW-1:0]   snk_data_i,
  input  logic            snk_valid_i,
  output logic            snk_ready_o,
  // TCDM master
  output logic            tcdm_req_o,
  input  logic            tcdm_gnt_i,
  output logic [AW-1:0]   tcdm_add_o,
  output logic            tcdm_wen_o,
  output logic [DW/8-1:0] tcdm_be_o,
  output logic [DW-1:0]   tcdm_data_o,
  input  logic [DW-1:0]   tcdm_r_data_i,
  input  logic            tcdm_r_valid_i,
  // status
  output logic            err_misaligned_o
);

  aes_port_state_t state, state_next;

  logic [AW-3:0] addr_q;     // word address; byte offset is never driven
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          dir_rd_q;   // direction of the transfer in flight
  logic          err_q;
  logic          drop_q;     // a read response is still owed after a clear
  logic          src_accept;
  logic          snk_accept;
  logic          drop_set;

  // Request handshake: source wins ties, clear blocks acceptance.
  always_comb begin
    src_ready_start_o = (state == IDLE) & ~drop_q;
    snk_ready_start_o = src_ready_start_o & ~src_req_start_i;
    src_accept        = src_req_start_i & src_ready_start_o & ~clear;
    snk_accept        = snk_req_start_i & snk_ready_start_o & ~clear;
    // A granted read whose response has not yet arrived must be swallowed.
    drop_set = ((state == RD_WAIT) & ~tcdm_r_valid_i)
             | ((state == RD_REQ)  & tcdm_gnt_i)
             | (drop_q & ~tcdm_r_valid_i);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next  = state;
    tcdm_req_o  = 1'b0;
    tcdm_wen_o  = 1'b0;
    tcdm_be_o   = '0;
    src_valid_o = 1'b0;
    snk_ready_o = 1'b0;
    src_done_o  = 1'b0;
    snk_done_o  = 1'b0;
    case (state)
      IDLE: begin
        if (src_accept)      state_next = RD_REQ;
        else if (snk_accept) state_next = WR_DATA;
      end
      RD_REQ: begin
        tcdm_req_o = 1'b1;
        tcdm_wen_o = 1'b1;
        tcdm_be_o  = '1;
        if (tcdm_gnt_i) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (tcdm_r_valid_i) state_next = RD_OUT;
      end
      RD_OUT: begin
        src_valid_o = 1'b1;
        if (src_ready_i) state_next = DONE;
      end
      WR_DATA: begin
        snk_ready_o = 1'b1;
        if (snk_valid_i) state_next = WR_REQ;
      end
      WR_REQ: begin
        tcdm_req_o = 1'b1;
        tcdm_be_o  = '1;
        if (tcdm_gnt_i) state_next = DONE;
      end
      DONE: begin
        src_done_o = dir_rd_q;
        snk_done_o = ~dir_rd_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Address, data, direction and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dir_rd_q <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else if (clear) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dir_rd_q <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= drop_set;
    end else begin
      if (drop_q && tcdm_r_valid_i) drop_q <= 1'b0;
      if (src_accept) begin
        addr_q   <= src_base_addr_i[AW-1:2];
        dir_rd_q <= 1'b1;
        if (src_base_addr_i[1:0] != 2'b00) err_q <= 1'b1;
      end else if (snk_accept) begin
        addr_q   <= snk_base_addr_i[AW-1:2];
        dir_rd_q <= 1'b0;
        if (snk_base_addr_i[1:0] != 2'b00) err_q <= 1'b1;
      end
      if (state == RD_WAIT && tcdm_r_valid_i) rdata_q <= tcdm_r_data_i;
      if (state == WR_DATA && snk_valid_i)    wdata_q <= snk_data_i;
    end
  end

  assign src_data_o       = rdata_q;
  assign tcdm_add_o       = {addr_q, 2'b00};
  assign tcdm_data_o      = wdata_q;
  assign err_misaligned_o = err_q;

endmodule

// File: tb/tb_aes_tcdm_word_port.sv
// Directed bench for aes_tcdm_word_port. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_aes_tcdm_word_port;

  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clear;
  logic            src_req_start_i;
  logic [AW-1:0]   src_base_addr_i;
  logic            src_ready_start_o;
  logic            src_done_o;
  logic [DW-1:0]   src_data_o;
  logic            src_valid_o;
  logic            src_ready_i;
  logic            snk_req_start_i;
  logic [AW-1:0]   snk_base_addr_i;
  logic            snk_ready_start_o;
  logic            snk_done_o;
  logic [DW-1:0]   snk_data_i;
  logic            snk_valid_i;
  logic            snk_ready_o;
  logic            tcdm_req_o;
  logic            tcdm_gnt_i;
  logic [AW-1:0]   tcdm_add_o;
  logic            tcdm_wen_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [DW-1:0]   tcdm_data_o;
  logic [DW-1:0]   tcdm_r_data_i;
  logic            tcdm_r_valid_i;
  logic            err_misaligned_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_tcdm_word_port #(.DW(DW), .AW(AW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clear             (clear),
    .src_req_start_i   (src_req_start_i),
    .src_base_addr_i   (src_base_addr_i),
    .src_ready_start_o (src_ready_start_o),
    .src_done_o        (src_done_o),
    .src_data_o        (src_data_o),
    .src_valid_o       (src_valid_o),
    .src_ready_i       (src_ready_i),
    .snk_req_start_i   (snk_req_start_i),
    .snk_base_addr_i   (snk_base_addr_i),
    .snk_ready_start_o (snk_ready_start_o),
    .snk_done_o        (snk_done_o),
    .snk_data_i        (snk_data_i),
    .snk_valid_i       (snk_valid_i),
    .snk_ready_o       (snk_ready_o),
    .tcdm_req_o        (tcdm_req_o),
    .tcdm_gnt_i        (tcdm_gnt_i),
    .tcdm_add_o        (tcdm_add_o),
    .tcdm_wen_o        (tcdm_wen_o),
    .tcdm_be_o         (tcdm_be_o),
    .tcdm_data_o       (tcdm_data_o),
    .tcdm_r_data_i     (tcdm_r_data_i),
    .tcdm_r_valid_i    (tcdm_r_valid_i),
    .err_misaligned_o  (err_misaligned_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    src_req_start_i = 1'b0; src_base_addr_i = '0; src_ready_i = 1'b0;
    snk_req_start_i = 1'b0; snk_base_addr_i = '0; snk_data_i = '0; snk_valid_i = 1'b0;
    tcdm_gnt_i = 1'b0; tcdm_r_data_i = '0; tcdm_r_valid_i = 1'b0;

    // ---------------- reset values ----------------
    tick(); tick();
    check("rst_src_ready_start", src_ready_start_o, 1);
    check("rst_snk_ready_start", snk_ready_start_o, 1);
    check("rst_tcdm_req", tcdm_req_o, 0);
    check("rst_be", tcdm_be_o, 0);
    check("rst_src_data", src_data_o, 0);
    check("rst_err", err_misaligned_o, 0);
    src_req_start_i = 1'b1;
    #1 check("rst_snk_ready_start_masked", snk_ready_start_o, 0);
    src_req_start_i = 1'b0;
    reset_n = 1'b1;
    tick();

    // ---------------- read 0x1000, zero-wait ----------------
    src_req_start_i = 1'b1; src_base_addr_i = 32'h1000;
    #1 check("rd_ready_start", src_ready_start_o, 1);
    tick(); // cycle 1: RD_REQ
    src_req_start_i = 1'b0; src_base_addr_i = '0;
    check("rd_req", tcdm_req_o, 1);
    check("rd_wen", tcdm_wen_o, 1);
    check("rd_be", tcdm_be_o, 4'hF);
    check("rd_add", tcdm_add_o, 32'h1000);
    check("rd_busy_ready_start", src_ready_start_o, 0);
    tcdm_gnt_i = 1'b1;
    tick(); // cycle 2: RD_WAIT
    tcdm_gnt_i = 1'b0;
    check("rd_wait_req", tcdm_req_o, 0);
    tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'hDEADBEEF;
    tick(); // cycle 3: RD_OUT
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    check("rd_valid", src_valid_o, 1);
    check("rd_data", src_data_o, 32'hDEADBEEF);
    src_ready_i = 1'b1;
    tick(); // cycle 4: DONE
    src_ready_i = 1'b0;
    check("rd_done_c4", src_done_o, 1);
    check("rd_no_snk_done", snk_done_o, 0);
    check("rd_valid_gone", src_valid_o, 0);
    tick();
    check("rd_done_once", src_done_o, 0);
    check("rd_back_idle", src_ready_start_o, 1);

    // ---------------- write 0x2004, grant after 3 wait cycles ----------------
    snk_req_start_i = 1'b1; snk_base_addr_i = 32'h2004;
    #1 check("wr_ready_start", snk_ready_start_o, 1);
    tick(); // WR_DATA
    snk_req_start_i = 1'b0; snk_base_addr_i = '0;
    check("wr_snk_ready", snk_ready_o, 1);
    check("wr_data_no_req", tcdm_req_o, 0);
    snk_valid_i = 1'b1; snk_data_i = 32'hCAFEF00D;
    tick(); // WR_REQ
    snk_valid_i = 1'b0; snk_data_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_req_%0d", i), tcdm_req_o, 1);
      check($sformatf("wr_wen_%0d", i), tcdm_wen_o, 0);
      check($sformatf("wr_be_%0d", i), tcdm_be_o, 4'hF);
      check($sformatf("wr_add_%0d", i), tcdm_add_o, 32'h2004);
      check($sformatf("wr_data_%0d", i), tcdm_data_o, 32'hCAFEF00D);
      check($sformatf("wr_no_done_%0d", i), snk_done_o, 0);
      tcdm_gnt_i = (i == 3);
      tick();
    end
    tcdm_gnt_i = 1'b0;
    check("wr_done", snk_done_o, 1);
    check("wr_no_src_done", src_done_o, 0);
    check("wr_req_dropped", tcdm_req_o, 0);
    tick();
    check("wr_done_once", snk_done_o, 0);
    check("wr_err_clean", err_misaligned_o, 0);

    // ---------------- simultaneous requests: read first ----------------
    src_req_start_i = 1'b1; src_base_addr_i = 32'h3000;
    snk_req_start_i = 1'b1; snk_base_addr_i = 32'h4000;
    #1 check("pri_snk_blocked", snk_ready_start_o, 0);
    tick(); // RD_REQ
    src_req_start_i = 1'b0;
    check("pri_read_first", tcdm_wen_o, 1);
    check("pri_add", tcdm_add_o, 32'h3000);
    // response in the grant cycle must be ignored
    tcdm_gnt_i = 1'b1; tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'hBADBAD00;
    tick(); // RD_WAIT
    tcdm_gnt_i = 1'b0; tcdm_r_data_i = 32'hA5A5A5A5;
    check("pri_rvalid_grant_ignored", src_valid_o, 0);
    tick(); // RD_OUT
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    check("pri_rd_data", src_data_o, 32'hA5A5A5A5);
    src_ready_i = 1'b1;
    tick(); // DONE
    src_ready_i = 1'b0;
    check("pri_src_done", src_done_o, 1);
    check("pri_snk_wait_in_done", snk_ready_start_o, 0);
    tick(); // IDLE: held sink request accepted here
    check("pri_snk_accept_idle", snk_ready_start_o, 1);
    tick(); // WR_DATA
    snk_req_start_i = 1'b0;
    check("pri_wr_data_state", snk_ready_o, 1);
    check("pri_wr_add", tcdm_add_o, 32'h4000);
    snk_valid_i = 1'b1; snk_data_i = 32'h0BADC0DE;
    tick(); // WR_REQ
    snk_valid_i = 1'b0;
    check("pri_wr_req", tcdm_req_o, 1);
    check("pri_wr_wdata", tcdm_data_o, 32'h0BADC0DE);
    tcdm_gnt_i = 1'b1;
    tick(); // DONE
    tcdm_gnt_i = 1'b0;
    check("pri_snk_done", snk_done_o, 1);
    tick();

    // ---------------- misaligned read 0x1002 ----------------
    src_req_start_i = 1'b1; src_base_addr_i = 32'h1002;
    tick(); // RD_REQ
    src_req_start_i = 1'b0;
    check("mis_add_aligned", tcdm_add_o, 32'h1000);
    check("mis_err_set", err_misaligned_o, 1);
    tcdm_gnt_i = 1'b1;
    tick();
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'h00C0FFEE;
    tick(); // RD_OUT, consumer stalls one cycle
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    tick();
    check("mis_valid_held", src_valid_o, 1);
    check("mis_data_held", src_data_o, 32'h00C0FFEE);
    src_ready_i = 1'b1;
    tick(); // DONE
    src_ready_i = 1'b0;
    check("mis_done", src_done_o, 1);
    tick();
    check("mis_err_sticky", err_misaligned_o, 1);
    // clear and a request in the same cycle: clear wins
    clear = 1'b1; src_req_start_i = 1'b1; src_base_addr_i = 32'h7000;
    tick();
    clear = 1'b0; src_req_start_i = 1'b0;
    check("clr_err_cleared", err_misaligned_o, 0);
    check("clr_req_not_accepted", tcdm_req_o, 0);
    check("clr_data_cleared", src_data_o, 0);
    check("clr_still_idle", src_ready_start_o, 1);

    // ---------------- clear after grant, late response dropped ----------------
    src_req_start_i = 1'b1; src_base_addr_i = 32'h5000;
    tick(); // RD_REQ
    src_req_start_i = 1'b0;
    tcdm_gnt_i = 1'b1;
    tick(); // RD_WAIT
    tcdm_gnt_i = 1'b0;
    clear = 1'b1;
    tick(); // IDLE, drop pending
    clear = 1'b0;
    src_req_start_i = 1'b1; src_base_addr_i = 32'h6000;
    #1 check("drop_src_ready_low", src_ready_start_o, 0);
    check("drop_snk_ready_low", snk_ready_start_o, 0);
    check("drop_no_valid", src_valid_o, 0);
    tick(); // still waiting for the orphan response
    check("drop_no_req", tcdm_req_o, 0);
    tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'h11111111;
    #1 check("drop_ready_low_at_rvalid", src_ready_start_o, 0);
    tick(); // response swallowed; request now accepted this cycle
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    check("drop_data_not_presented", src_data_o, 0);
    check("drop_no_done", src_done_o, 0);
    check("drop_ready_restored", src_ready_start_o, 1);
    tick(); // RD_REQ for 0x6000
    src_req_start_i = 1'b0;
    check("post_drop_req", tcdm_req_o, 1);
    check("post_drop_add", tcdm_add_o, 32'h6000);
    tcdm_gnt_i = 1'b1;
    tick();
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'h12345678;
    tick();
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    check("post_drop_data", src_data_o, 32'h12345678);
    src_ready_i = 1'b1;
    tick();
    src_ready_i = 1'b0;
    check("post_drop_done", src_done_o, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_tcdm_word_port.md
AES_TCDM_WORD_PORT -- requirements
Module: aes_tcdm_word_port

Interface
REQ-001 SHALL have parameters DW (default 32, data width) and AW (default 32, address width).
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous soft clear.
REQ-005 src_req_start_i  input  1  read-word request; src_base_addr_i  input  AW  read byte address.
REQ-006 src_ready_start_o  output  1  read request accepted; src_done_o  output  1  read-word completion pulse.
REQ-007 src_data_o  output  DW  read word; src_valid_o  output  1  word valid; src_ready_i  input  1  consumer ready.
REQ-008 snk_req_start_i  input  1  write-word request; snk_base_addr_i  input  AW  write byte address.
REQ-009 snk_ready_start_o  output  1  write request accepted; snk_done_o  output  1  write-word completion pulse.
REQ-010 snk_data_i  input  DW  word to write; snk_valid_i  input  1  word valid; snk_ready_o  output  1  port ready.
REQ-011 tcdm_req_o  output  1; tcdm_gnt_i  input  1; tcdm_add_o  output  AW; tcdm_wen_o  output  1 (1 = read, 0 = write); tcdm_be_o  output  DW/8; tcdm_data_o  output  DW; tcdm_r_data_i  input  DW; tcdm_r_valid_i  input  1.
REQ-012 err_misaligned_o  output  1  sticky flag, set by a base address with non-zero low two bits.

Function
REQ-013 FSM states: IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ, DONE.
REQ-014 src_ready_start_o = (state==IDLE); snk_ready_start_o = (state==IDLE) & ~src_req_start_i; a request is accepted when req_start and ready_start are both high in the same cycle.
REQ-015 Source has priority on simultaneous requests: IDLE->RD_REQ; a sink request is not accepted that cycle and must be held by the requester.
REQ-016 At acceptance, base address latched; tcdm_add_o = {addr[AW-1:2],2'b00}; err_misaligned_o set if addr[1:0]!=0; the transfer still proceeds, aligned.
REQ-017 RD_REQ: tcdm_req_o=1, tcdm_wen_o=1, tcdm_be_o all ones; address stable until tcdm_gnt_i; on grant -> RD_WAIT.
REQ-018 RD_WAIT: on tcdm_r_valid_i, latch tcdm_r_data_i into src_data_o -> RD_OUT; r_valid is never honoured in the grant cycle.
REQ-019 RD_OUT: src_valid_o=1, src_data_o stable until src_ready_i; on handshake -> DONE.
REQ-020 A sink request goes from IDLE to WR_DATA; there snk_ready_o=1, and on snk_valid_i the word is latched -> WR_REQ.
REQ-021 WR_REQ: tcdm_req_o=1, tcdm_wen_o=0, tcdm_be_o all ones, tcdm_data_o = latched word, all stable until tcdm_gnt_i; on grant -> DONE.
REQ-022 DONE lasts exactly one cycle and then goes to IDLE; it pulses src_done_o or snk_done_o, matching the completed direction.
REQ-023 Minimum read latency is 4 cycles from acceptance to done, with zero-wait grant and r_valid one cycle after grant; minimum write latency is 3 cycles.
REQ-024 tcdm_req_o SHALL never be deasserted before grant; no more than one TCDM transaction is outstanding.
REQ-025 On clear: state goes to IDLE, outputs to their reset values, and err_misaligned_o is cleared.
REQ-026 If clear lands in RD_WAIT after a grant, a drop_pending flag is set; the next tcdm_r_valid_i is discarded and clears the flag.
REQ-027 While drop_pending=1, src_ready_start_o and snk_ready_start_o are held low.
REQ-028 When clear and a request arrive in the same cycle, clear wins and the request is not accepted.

Reset
REQ-029 Async reset_n low: state=IDLE, drop_pending=0, err_misaligned_o=0, src_data_o=0, latched address and write data=0.
REQ-030 All other outputs during reset are 0, except src_ready_start_o=1 and snk_ready_start_o=~src_req_start_i, both decoded from IDLE.

Structure
REQ-031 The state enum aes_port_state_t belongs in aes_package, next to the existing AES state type.
REQ-032 No sub-module: a single FSM plus registers; the TCDM signals are flat ports.

Verification
REQ-033 Read at 0x1000, gnt immediate, r_data=0xDEADBEEF next cycle, src_ready_i=1 -> src_valid_o with 0xDEADBEEF, src_done_o pulses at cycle 4, tcdm_add_o=0x1000.
REQ-034 Write at 0x2004 with data 0xCAFEF00D, gnt delayed 3 cycles -> tcdm_req_o held for 4 cycles with wen=0, be=0xF, stable address and data; snk_done_o pulses once.
REQ-035 src and snk req_start in the same IDLE cycle -> read served first; the held sink request is accepted in the first IDLE cycle after src_done_o.
REQ-036 Read at 0x1002 -> tcdm_add_o=0x1000, err_misaligned_o=1 until clear.
REQ-037 clear one cycle after a read grant, r_valid arrives 2 cycles later -> data not presented, no done pulse, ready_start low until that r_valid, then normal operation.
